// File: rtl/rx2in_ctl_pkg.sv
// Shared definitions for the UART receive-side flow controller:
// software flow-control bytes and the flow-control FSM encoding.
package rx2in_ctl_pkg;

    localparam logic [7:0] XON  = 8'h11;
    localparam logic [7:0] XOFF = 8'h13;

    typedef enum logic [1:0] {
        FC_ON       = 2'd0,
        FC_SEND_OFF = 2'd1,
        FC_OFF      = 2'd2,
        FC_SEND_ON  = 2'd3
    } fc_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous DEPTH x 8 FIFO with separate occupancy counter.
// Caller must never push when full without popping, nor pop when empty.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    head,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;

    assign head  = mem[rptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
        end
    end

endmodule

// File: rtl/rx2in_ctl.sv
// UART RX to INBOX controller: buffers received bytes, drains them
// into the INBOX and requests XOFF/XON as the buffer fills/empties.
import rx2in_ctl_pkg::*;

module rx2in_ctl #(
    parameter int DEPTH    = 8,
    parameter int HI_WATER = 6,
    parameter int LO_WATER = 2
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     i_wr,
    input  logic [7:0]               i_data,
    input  logic                     i_full,
    output logic                     o_wr,
    output logic [7:0]               o_data,
    output logic                     o_fc_req,
    output logic [7:0]               o_fc_byte,
    input  logic                     i_fc_ack,
    output logic                     o_overflow,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] HI = LW'(HI_WATER);
    localparam logic [LW-1:0] LO = LW'(LO_WATER);

    logic [7:0]    head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          push;
    logic [LW-1:0] lvl_nxt;
    fc_state_t     state;
    fc_state_t     state_nxt;

    // The !o_wr term leaves i_full a cycle to reflect the last write.
    assign pop  = !empty && !i_full && !o_wr;
    assign push = i_wr && (!full || pop);

    byte_fifo #(
        .DEPTH (DEPTH),
        .LW    (LW)
    ) u_fifo (
        .clk   (clk),
        .rst   (i_rst),
        .push  (push),
        .pop   (pop),
        .din   (i_data),
        .head  (head),
        .level (o_level),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        lvl_nxt = o_level;
        if (push && !pop) begin
            lvl_nxt = o_level + 1'b1;
        end else if (pop && !push) begin
            lvl_nxt = o_level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_wr       <= 1'b0;
            o_data     <= 8'h00;
            o_overflow <= 1'b0;
        end else begin
            o_wr <= pop;
            if (pop) begin
                o_data <= head;
            end
            if (i_wr && !push) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Watermarks use the upcoming level so the request rises on the
    // cycle right after the crossing edge.
    always_comb begin
        state_nxt = state;
        unique case (state)
            FC_ON:       if (lvl_nxt >= HI) state_nxt = FC_SEND_OFF;
            FC_SEND_OFF: if (i_fc_ack)      state_nxt = FC_OFF;
            FC_OFF:      if (lvl_nxt <= LO) state_nxt = FC_SEND_ON;
            FC_SEND_ON:  if (i_fc_ack)      state_nxt = FC_ON;
            default:                        state_nxt = FC_ON;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state     <= FC_ON;
            o_fc_req  <= 1'b0;
            o_fc_byte <= XON;
        end else begin
            state    <= state_nxt;
            o_fc_req <= (state_nxt == FC_SEND_OFF)
                     || (state_nxt == FC_SEND_ON);
            if (state_nxt == FC_SEND_OFF) begin
                o_fc_byte <= XOFF;
            end else if (state_nxt == FC_SEND_ON) begin
                o_fc_byte <= XON;
            end
        end
    end

endmodule

// File: tb/tb_rx2in_ctl.sv
// Scenario bench for rx2in_ctl with a byte scoreboard on the INBOX side.
module tb_rx2in_ctl;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_wr = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_full = 1'b0;
    logic       o_wr;
    logic [7:0] o_data;
    logic       o_fc_req;
    logic [7:0] o_fc_byte;
    logic       i_fc_ack = 1'b0;
    logic       o_overflow;
    logic [3:0] o_level;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];
    logic       prev_wr = 1'b0;
    logic       prev_full = 1'b0;

    always #5 clk = ~clk;

    rx2in_ctl #(
        .DEPTH    (8),
        .HI_WATER (6),
        .LO_WATER (2)
    ) dut (
        .clk        (clk),
        .i_rst      (i_rst),
        .i_wr       (i_wr),
        .i_data     (i_data),
        .i_full     (i_full),
        .o_wr       (o_wr),
        .o_data     (o_data),
        .o_fc_req   (o_fc_req),
        .o_fc_byte  (o_fc_byte),
        .i_fc_ack   (i_fc_ack),
        .o_overflow (o_overflow),
        .o_level    (o_level)
    );

    // INBOX-side monitor: order, spacing and i_full respect.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!i_rst && o_wr === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL sb_extra: o_data=%h, expected no write", o_data);
            end else begin
                e = exp_q.pop_front();
                if (o_data !== e) begin
                    fails++;
                    $display("FAIL sb_data: o_data=%h, expected %h", o_data, e);
                end
            end
            tests++;
            if (prev_wr !== 1'b0) begin
                fails++;
                $display("FAIL wr_gap: back-to-back o_wr, expected idle gap");
            end
            tests++;
            if (prev_full !== 1'b0) begin
                fails++;
                $display("FAIL wr_after_full: o_wr=1 after i_full=1, expected 0");
            end
        end
        prev_wr   = o_wr;
        prev_full = i_full;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b, input logic keep);
        i_wr   = 1'b1;
        i_data = b;
        if (keep) exp_q.push_back(b);
        tick();
        i_wr = 1'b0;
    endtask

    task automatic ack_fc();
        if (o_fc_req) begin
            i_fc_ack = 1'b1;
            tick();
            i_fc_ack = 1'b0;
        end
    endtask

    task automatic wait_empty(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
        tick();
        tick();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        exp_q.delete();
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        tests++;
        if (o_wr !== 1'b0 || o_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_wr: o_wr=%b o_data=%h, expected 0/00", o_wr, o_data);
        end
        tests++;
        if (o_fc_req !== 1'b0 || o_fc_byte !== 8'h11) begin
            fails++;
            $display("FAIL reset_fc: req=%b byte=%h, expected 0/11", o_fc_req, o_fc_byte);
        end
        tests++;
        if (o_overflow !== 1'b0 || o_level !== 4'd0) begin
            fails++;
            $display("FAIL reset_lvl: ovf=%b level=%0d, expected 0/0", o_overflow, o_level);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_single();
        i_full = 1'b0;
        push_byte(8'hA5, 1'b1);
        tests++;
        if (o_level !== 4'd1) begin
            fails++;
            $display("FAIL single_lvl: level=%0d, expected 1", o_level);
        end
        wait_empty(10);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL single_timeout: %0d bytes pending, expected 0", exp_q.size());
        end
        tests++;
        if (o_level !== 4'd0 || o_fc_req !== 1'b0) begin
            fails++;
            $display("FAIL single_end: level=%0d req=%b, expected 0/0", o_level, o_fc_req);
        end
    endtask

    task automatic test_xoff();
        i_full = 1'b1;
        for (int i = 1; i <= 6; i++) push_byte(8'(i), 1'b1);
        tests++;
        if (o_level !== 4'd6 || o_wr !== 1'b0) begin
            fails++;
            $display("FAIL xoff_lvl: level=%0d o_wr=%b, expected 6/0", o_level, o_wr);
        end
        tests++;
        if (o_fc_req !== 1'b1 || o_fc_byte !== 8'h13) begin
            fails++;
            $display("FAIL xoff_req: req=%b byte=%h, expected 1/13", o_fc_req, o_fc_byte);
        end
        tick();
        tick();
        tick();
        tests++;
        if (o_fc_req !== 1'b1) begin
            fails++;
            $display("FAIL xoff_hold: req=%b, expected 1", o_fc_req);
        end
        i_fc_ack = 1'b1;
        tick();
        i_fc_ack = 1'b0;
        tests++;
        if (o_fc_req !== 1'b0 || o_fc_byte !== 8'h13) begin
            fails++;
            $display("FAIL xoff_ack: req=%b byte=%h, expected 0/13", o_fc_req, o_fc_byte);
        end
    endtask

    task automatic test_xon_drain();
        int n;
        i_full = 1'b0;
        n = 0;
        while (o_fc_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (o_fc_req !== 1'b1 || o_fc_byte !== 8'h11 || o_level !== 4'd2) begin
            fails++;
            $display("FAIL xon_req: req=%b byte=%h level=%0d, expected 1/11/2",
                     o_fc_req, o_fc_byte, o_level);
        end
        i_fc_ack = 1'b1;
        tick();
        i_fc_ack = 1'b0;
        tests++;
        if (o_fc_req !== 1'b0) begin
            fails++;
            $display("FAIL xon_ack: req=%b, expected 0", o_fc_req);
        end
        wait_empty(40);
        tests++;
        if (exp_q.size() != 0 || o_level !== 4'd0 || o_fc_req !== 1'b0) begin
            fails++;
            $display("FAIL xon_drain: pending=%0d level=%0d req=%b, expected 0/0/0",
                     exp_q.size(), o_level, o_fc_req);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        i_full = 1'b1;
        for (int i = 0; i < 9; i++) push_byte(8'h20 + 8'(i), i < 8);
        tests++;
        if (o_level !== 4'd8 || o_overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_set: level=%0d ovf=%b, expected 8/1", o_level, o_overflow);
        end
        ack_fc();
        i_full = 1'b0;
        wait_empty(60);
        tests++;
        if (exp_q.size() != 0 || o_level !== 4'd0) begin
            fails++;
            $display("FAIL ovf_drain: pending=%0d level=%0d, expected 0/0",
                     exp_q.size(), o_level);
        end
        tests++;
        if (o_overflow !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky: ovf=%b, expected 1", o_overflow);
        end
        ack_fc();
    endtask

    task automatic test_full_push_pop();
        do_reset();
        i_full = 1'b1;
        for (int i = 0; i < 8; i++) push_byte(8'h40 + 8'(i), 1'b1);
        ack_fc();
        i_full = 1'b0;
        push_byte(8'h55, 1'b1);
        tests++;
        if (o_level !== 4'd8 || o_overflow !== 1'b0 || o_wr !== 1'b1) begin
            fails++;
            $display("FAIL full_pushpop: level=%0d ovf=%b wr=%b, expected 8/0/1",
                     o_level, o_overflow, o_wr);
        end
        wait_empty(60);
        tests++;
        if (exp_q.size() != 0 || o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_drain: pending=%0d ovf=%b, expected 0/0",
                     exp_q.size(), o_overflow);
        end
        ack_fc();
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        i_full = 1'b1;
        for (int i = 0; i < 7; i++) push_byte(8'h60 + 8'(i), 1'b1);
        tests++;
        if (o_fc_req !== 1'b1 || o_level !== 4'd7) begin
            fails++;
            $display("FAIL rst_pre: req=%b level=%0d, expected 1/7", o_fc_req, o_level);
        end
        i_rst = 1'b1;
        exp_q.delete();
        tick();
        i_rst = 1'b0;
        tests++;
        if (o_fc_req !== 1'b0 || o_fc_byte !== 8'h11 || o_level !== 4'd0) begin
            fails++;
            $display("FAIL rst_mid: req=%b byte=%h level=%0d, expected 0/11/0",
                     o_fc_req, o_fc_byte, o_level);
        end
        tests++;
        if (o_wr !== 1'b0 || o_data !== 8'h00 || o_overflow !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_out: wr=%b data=%h ovf=%b, expected 0/00/0",
                     o_wr, o_data, o_overflow);
        end
        i_fc_ack = 1'b1;
        tick();
        i_fc_ack = 1'b0;
        tick();
        tests++;
        if (o_fc_req !== 1'b0 || o_fc_byte !== 8'h11) begin
            fails++;
            $display("FAIL rst_ack_ign: req=%b byte=%h, expected 0/11", o_fc_req, o_fc_byte);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_xoff();
        test_xon_drain();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_req();
        i_full = 1'b0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
